mem_bus_ctrl: RTL and testbench

- Parametrised data-memory bus controller between the multicycle datapath and the external memory bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Replaces direct combinational bus driving with a registered request FSM:
  - variable wait states via the ACKD_n handshake;
  - byte/halfword lane steering on stores;
  - lane extraction and sign/zero extension on loads;
  - misalignment rejection.
- The datapath issues one request and stalls on busy until done or err.

---
 rtl/mem_bus_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Data-memory bus controller: registered request FSM with ACKD_n wait states,
// store lane replication, load lane extraction/extension, misalignment rejection.
// Optional bus timeout enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_ctrl #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [1:0]  SIZE_BYTE   = 2'b00,
  parameter logic [1:0]  SIZE_HALF   = 2'b01,
  parameter logic [1:0]  SIZE_WORD   = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] DAD,
  output logic              MREQ,
  output logic              WRITE,
  output logic [1:0]        SIZE,
  input  logic              ACKD_n,
  inout  wire  [31:0]       DDT
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic              we_q;
  logic              sext_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              aligned;
  logic              accept;
  logic              capture;
  logic              err_nxt;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext;
  logic [31:0]       store_bus;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CNT_W-1:0] wait_cnt;
`endif

  always_comb begin
    case (size)
      SIZE_BYTE: aligned = 1'b1;
      SIZE_HALF: aligned = ~addr[0];
      SIZE_WORD: aligned = (addr[1:0] == 2'b00);
      default:   aligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (aligned) begin
            accept    = 1'b1;
            state_nxt = ACCESS;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      ACCESS: begin
        // Acknowledge is tested first so it wins over a timeout on the same edge.
        if (!ACKD_n) begin
          capture   = ~we_q;
          state_nxt = RESP;
        end
`ifdef MEM_BUS_TIMEOUT_EN
        else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           wait_cnt <= '0;
    else if (accept)                    wait_cnt <= '0;
    else if (state == ACCESS && ACKD_n) wait_cnt <= wait_cnt + CNT_W'(1);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      sext_q  <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_nxt;
      if (accept) begin
        we_q    <= we;
        sext_q  <= sext;
        size_q  <= size;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (capture) rdata_q <= load_ext;
    end
  end

  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = DDT[7:0];
      2'd1:    lane_b = DDT[15:8];
      2'd2:    lane_b = DDT[23:16];
      default: lane_b = DDT[31:24];
    endcase
    lane_h = addr_q[1] ? DDT[31:16] : DDT[15:0];
    case (size_q)
      SIZE_BYTE: load_ext = {{24{sext_q & lane_b[7]}}, lane_b};
      SIZE_HALF: load_ext = {{16{sext_q & lane_h[15]}}, lane_h};
      default:   load_ext = DDT;
    endcase
  end

  always_comb begin
    case (size_q)
      SIZE_BYTE: store_bus = {4{wdata_q[7:0]}};
      SIZE_HALF: store_bus = {2{wdata_q[15:0]}};
      default:   store_bus = wdata_q;
    endcase
  end

  assign MREQ  = (state == ACCESS);
  assign WRITE = MREQ & we_q;
  assign busy  = (state == ACCESS);
  assign done  = (state == RESP);
  assign err   = err_q;
  assign rdata = rdata_q;
  assign SIZE  = size_q;
  assign DAD   = {addr_q[ADDR_W-1:2], 2'b00};
  assign DDT   = (MREQ && WRITE) ? store_bus : {32{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: directed accesses push expected responses,
// a negedge monitor pops and compares on done/err.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, err;
  logic [31:0] DAD;
  logic        MREQ, WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n = 1'b1;
  wire  [31:0] ddt;
  logic        bus_drv = 1'b0;
  logic [31:0] bus_val = '0;

  assign ddt = bus_drv ? bus_val : {32{1'bz}};

  always #5 clk = ~clk;

  mem_bus_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sext(sext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .err(err), .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .ACKD_n(ACKD_n), .DDT(ddt)
  );

  typedef struct {
    logic        is_err;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", name, act, exp);
    end
  endtask

  // Monitor: every done/err pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst && (done || err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", {30'd0, done, err}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_kind", {30'd0, done, err}, e.is_err ? 32'd1 : 32'd2);
        if (!e.is_err) check("rdata", rdata, e.rdata);
      end
    end
  end

  task automatic do_access(input logic wr, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int unsigned waits, input logic [31:0] bus_rd,
                           input logic [31:0] exp_rd, input logic [31:0] exp_ddt);
    exp_q.push_back('{is_err: 1'b0, rdata: exp_rd});
    req = 1'b1; we = wr; size = sz; sext = sx; addr = a; wdata = wd; ACKD_n = 1'b1;
    @(posedge clk); #1;
    // scramble inputs while busy; they must not affect the bus cycle
    req = 1'b0; we = ~wr; size = 2'b11; addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD;
    for (int unsigned c = 0; c <= waits; c++) begin
      if (c == waits) begin
        ACKD_n = 1'b0;
        if (!wr) begin bus_drv = 1'b1; bus_val = bus_rd; end
      end
      @(negedge clk);
      check("busy_access", {31'd0, busy}, 32'd1);
      check("mreq_access", {31'd0, MREQ}, 32'd1);
      check("done_access", {31'd0, done}, 32'd0);
      check("write", {31'd0, WRITE}, {31'd0, wr});
      check("dad", DAD, a & 32'hFFFF_FFFC);
      check("size", {30'd0, SIZE}, {30'd0, sz});
      if (wr) check("ddt_store", ddt, exp_ddt);
      @(posedge clk); #1;
      ACKD_n = 1'b1; bus_drv = 1'b0;
    end
    // RESP cycle: a request here must be ignored
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0;
    @(negedge clk);
    check("done_resp", {31'd0, done}, 32'd1);
    check("busy_resp", {31'd0, busy}, 32'd0);
    check("mreq_resp", {31'd0, MREQ}, 32'd0);
    @(posedge clk); #1;
    req = 1'b0;
    bus_drv = 1'b1; bus_val = 32'h0;
    @(negedge clk);
    check("resp_req_ignored", {31'd0, MREQ}, 32'd0);
    check("ddt_released", ddt, 32'h0);
    @(posedge clk); #1;
    bus_drv = 1'b0;
  endtask

  task automatic do_bad(input logic [1:0] sz, input logic [31:0] a);
    exp_q.push_back('{is_err: 1'b1, rdata: 32'h0});
    req = 1'b1; we = 1'b0; size = sz; addr = a;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("bad_err", {31'd0, err}, 32'd1);
    check("bad_mreq", {31'd0, MREQ}, 32'd0);
    check("bad_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bad_err_pulse", {31'd0, err}, 32'd0);
    check("bad_mreq2", {31'd0, MREQ}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check("rst_mreq", {31'd0, MREQ}, 32'd0);
    check("rst_write", {31'd0, WRITE}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_size", {30'd0, SIZE}, 32'd0);
    check("rst_dad", DAD, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0);
    do_access(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 3, 32'h80FF_1234, 32'hFFFF_FF80, 32'h0);
    do_access(1'b1, 2'b01, 1'b0, 32'h302, 32'h0000_ABCD, 0, 32'h0, 32'hFFFF_FF80, 32'hABCD_ABCD);
    do_access(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 0, 32'h8765_4321, 32'h0000_8765, 32'h0);
    do_access(1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 2, 32'h1234_F00D, 32'hFFFF_F00D, 32'h0);
    do_access(1'b1, 2'b00, 1'b0, 32'h001, 32'h0000_005A, 0, 32'h0, 32'hFFFF_F00D, 32'h5A5A_5A5A);
    do_access(1'b1, 2'b10, 1'b0, 32'h040, 32'h1234_5678, 1, 32'h0, 32'hFFFF_F00D, 32'h1234_5678);
    do_access(1'b0, 2'b00, 1'b0, 32'h001, 32'h0, 0, 32'h0000_C300, 32'h0000_00C3, 32'h0);
    do_access(1'b0, 2'b00, 1'b1, 32'h002, 32'h0, 1, 32'h007F_0000, 32'h0000_007F, 32'h0);

    do_bad(2'b10, 32'h101);
    do_bad(2'b01, 32'h201);
    do_bad(2'b11, 32'h000);
    do_bad(2'b10, 32'h102);

    // reset during the second ACCESS cycle of a word store
    req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h80; wdata = 32'hCAFE_F00D; ACKD_n = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    check("mid_write_before", {31'd0, WRITE}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("mid_rst_mreq", {31'd0, MREQ}, 32'd0);
    check("mid_rst_write", {31'd0, WRITE}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_dad", DAD, 32'd0);
    check("mid_rst_rdata", rdata, 32'd0);
    bus_drv = 1'b1; bus_val = 32'h0;
    #1;
    check("mid_rst_ddt", ddt, 32'h0);
    bus_drv = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    do_access(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 0, 32'h0A0B_0C0D, 32'h0A0B_0C0D, 32'h0);

`ifdef MEM_BUS_TIMEOUT_EN
    begin
      int mreq_cycles;
      mreq_cycles = 0;
      exp_q.push_back('{is_err: 1'b1, rdata: 32'h0});
      req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h10; ACKD_n = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (MREQ) mreq_cycles++;
        else break;
      end
      check("to_mreq_cycles", mreq_cycles, 32'd4);
      check("to_err", {31'd0, err}, 32'd1);
      @(posedge clk); #1;
    end
    do_access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 3, 32'h5555_AAAA, 32'h5555_AAAA, 32'h0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
